uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
// Shares the single UART byte transmitter between two word-level requesters:
// req0 is the core's output instruction and req1 is the debug/trace unit.
// Round-robin arbitration is done at word granularity, so a granted word is never split.
// The granted word is serialised into 1..4 bytes and fed to the transmitter's 8-bit
// valid/ready port. The block sits between the core/debug logic and the UART transmitter.
// PARAMETERS
// LITTLE_ENDIAN  1     1: send byte [7:0] first; 0: send the most significant valid byte first
// CNT_WIDTH      16    width of bytes_sent statistics counter
// PORTS
// CLK          in   1          system clock, all logic on posedge
// RST          in   1          synchronous reset, active-high
// req0_valid   in   1          requester 0 (core) has a word
// req0_data    in   32         word; only the low (req0_len+1) bytes are meaningful
// req0_len     in   2          byte count minus 1 (0 = 1 byte, 3 = 4 bytes)
// req0_ready   out  1          word accepted when req0_valid && req0_ready
// req1_valid   in   1          requester 1 (debug) has a word
// req1_data    in   32         as req0_data
// req1_len     in   2          as req0_len
// req1_ready   out  1          as req0_ready
// tx_data      out  8          byte to the UART transmitter
// tx_valid     out  1          tx_data valid
// tx_ready     in   1          transmitter can accept; byte is taken when tx_valid && tx_ready
// busy         out  1          a word is held (state SEND)
// grant_id     out  1          owner of the held word; holds the last owner while IDLE
// bytes_sent   out  CNT_WIDTH  count of bytes handed over; wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
// - States: IDLE, SEND. Registers: buf[31:0], remain[1:0], last_grant, bytes_sent.
// - Reset (RST=1 at posedge):
//   - state <= IDLE; last_grant <= 1, so req0 wins the first tie.
//   - bytes_sent <= 0; grant_id <= 0.
//   - Outputs after reset: tx_valid=0, busy=0, req*_ready=0 until IDLE selects.
// - IDLE selection (combinational):
//   - sel = the single valid requester.
//   - If both are valid, sel = !last_grant.
//   - req_sel_ready = 1 while IDLE and req_sel_valid. The other ready = 0.
//   - A requester's ready is never asserted without its own valid.
// - Accept (IDLE, handshake at posedge):
//   - buf <= data; remain <= len; grant_id <= sel; last_grant <= sel; state <= SEND.
//   - If LITTLE_ENDIAN=0, buf is pre-aligned so the top meaningful byte sits in [7:0] order.
// - SEND:
//   - tx_valid = 1 and tx_data = buf[7:0] (registered, glitch-free).
//   - The first byte appears 1 cycle after accept.
//   - On tx_valid && tx_ready: bytes_sent += 1, buf shifts by 8, remain -= 1.
//   - If remain was 0 at that handshake: state <= IDLE and tx_valid = 0 next cycle.
// - Throughput: one byte per tx_ready handshake. No idle gap is inserted by this block.
//   The transmitter's own ready drop paces the UART line.
// - The next word can be accepted in the cycle after the final byte handshake.
//   Requesters see no ready while SEND.
// - tx_data/tx_valid hold stable while tx_valid && !tx_ready.
// - Requester inputs are ignored outside the accept cycle, and may change after the handshake.
// - Fairness: with both requesters valid continuously, grants alternate 0,1,0,1...
//   Neither requester waits more than one word.
// - Reset mid-SEND: the word is dropped and tx_valid = 0 from the next cycle.
//   A byte already handed to the transmitter still completes on the line.
// - Simultaneous last-byte handshake and a new req_valid: the new word is accepted in the
//   following IDLE cycle, never in the same cycle.
// - bytes_sent wraps from all-ones to 0 with no flag.
// TESTING
// - Reset, then req0 valid, data=0x44332211, len=3, tx_ready tied 1
//   -> tx_data sequence 11,22,33,44 on consecutive cycles; bytes_sent=4; req0_ready high 1 cycle.
// - LITTLE_ENDIAN=0, req1 data=0x0000BEEF, len=1 -> bytes BE then EF; grant_id=1.
// - Both requesters valid continuously, len=0, data 0xA0 / 0xB0
//   -> tx bytes A0,B0,A0,B0; req0 wins first after reset.
// - tx_ready low for 50 cycles mid-word -> tx_data/tx_valid stable; no byte lost or duplicated.
// - RST pulse while in SEND after 2 of 4 bytes -> tx_valid=0 next cycle; bytes_sent=0;
//   next request starts cleanly from byte 0.
// - CNT_WIDTH=4, send 17 single-byte words -> bytes_sent wraps to 1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// ----------------------------------------------------------------------------
// Shares one 8-bit UART transmitter between two word-level requesters.
// req0 is the core's output path and req1 is the debug/trace unit.
// Arbitration is round-robin at word granularity, so a granted word is never
// interleaved with the other requester's bytes. The held word is serialised
// into 1..4 bytes on a valid/ready byte port.
//
// Parameters
//   LITTLE_ENDIAN : 1 = send byte [7:0] first, 0 = most significant valid byte first
//   CNT_WIDTH     : width of the bytes_sent statistics counter (wraps silently)
//
// Ports
//   CLK, RST                 clock (posedge) and synchronous active-high reset
//   reqN_valid/data/len      word offer; len = byte count minus 1
//   reqN_ready               accept strobe (only while IDLE and own valid high)
//   tx_data/tx_valid/tx_ready byte stream to the UART transmitter
//   busy                     a word is held (SEND)
//   grant_id                 owner of the held word, last owner while IDLE
//   bytes_sent               number of bytes handed to the transmitter
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned LITTLE_ENDIAN = 1,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req0_valid,
    input  logic [31:0]          req0_data,
    input  logic [1:0]           req0_len,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [31:0]          req1_data,
    input  logic [1:0]           req1_len,
    output logic                 req1_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 grant_id,
    output logic [CNT_WIDTH-1:0] bytes_sent
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [31:0]          word_buf_q;
    logic [1:0]           remain_q;
    logic                 last_grant_q;
    logic                 grant_id_q;
    logic [CNT_WIDTH-1:0] bytes_sent_q;

    logic                 sel;
    logic                 accept;
    logic                 tx_hs;
    logic [31:0]          sel_data;
    logic [1:0]           sel_len;

    // Reverse the meaningful bytes so the most significant valid byte lands
    // in [7:0]; the shared right-shift serialiser then emits MSB first.
    function automatic logic [31:0] align_word(input logic [31:0] data,
                                               input logic [1:0]  len);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            if (i <= int'(len)) begin
                res[8*i +: 8] = data[8*(int'(len) - i) +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        state_d    = state_q;
        sel        = 1'b0;
        accept     = 1'b0;
        tx_hs      = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the requester that did not win last time goes next.
                if (req0_valid && req1_valid) begin
                    sel = ~last_grant_q;
                end else begin
                    sel = req1_valid;
                end
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    req0_ready = ~sel;
                    req1_ready = sel;
                    state_d    = SEND;
                end
            end
            SEND: begin
                tx_hs = tx_ready;
                if (tx_ready && (remain_q == 2'd0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_data = sel ? req1_data : req0_data;
        sel_len  = sel ? req1_len  : req0_len;
    end

    // Control registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            bytes_sent_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= sel;
                grant_id_q   <= sel;
            end
            if (tx_hs) begin
                bytes_sent_q <= bytes_sent_q + CNT_WIDTH'(1);
            end
        end
    end

    // Word buffer and byte countdown; only meaningful while SEND
    always_ff @(posedge CLK) begin
        if (accept) begin
            word_buf_q <= (LITTLE_ENDIAN != 0) ? sel_data : align_word(sel_data, sel_len);
            remain_q   <= sel_len;
        end else if (tx_hs) begin
            word_buf_q <= {8'h00, word_buf_q[31:8]};
            remain_q   <= remain_q - 2'd1;
        end
    end

    assign tx_valid   = (state_q == SEND);
    assign busy       = (state_q == SEND);
    assign tx_data    = word_buf_q[7:0];
    assign grant_id   = grant_id_q;
    assign bytes_sent = bytes_sent_q;

endmodule
